// File: rtl/ibex_lsu_lite.sv
// Load/store unit: turns one EX memory request into one or two aligned bus
// transactions and assembles the load result or error response.
module ibex_lsu_lite (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [1:0]  lsu_type_i,
    input  logic        lsu_sign_ext_i,
    input  logic [31:0] lsu_wdata_i,
    input  logic [31:0] adder_result_ex_i,
    output logic        lsu_req_done_o,

    output logic        data_req_o,
    input  logic        data_gnt_i,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_rvalid_i,
    input  logic        data_err_i,
    input  logic [31:0] data_rdata_i,

    output logic [31:0] lsu_rdata_o,
    output logic        lsu_rdata_valid_o,
    output logic        lsu_resp_valid_o,
    output logic        lsu_resp_err_o,
    output logic        load_err_o,
    output logic        store_err_o,
    output logic        busy_o
);

    localparam int unsigned DW  = 32;
    localparam int unsigned BEW = 4;

    localparam logic [1:0] TYPE_HALF = 2'd1;
    localparam logic [1:0] TYPE_BYTE = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_GNT_MIS,
        WAIT_RVALID_MIS,
        WAIT_GNT,
        WAIT_RVALID
    } state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   addr_q, addr_d;
    logic [1:0]      type_q, type_d;
    logic            we_q, we_d;
    logic            sign_q, sign_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            err_q, err_d;

    logic            req_c;
    logic            part2_c;
    logic            done_c;
    logic            resp_c;

    logic [DW-1:0]   cur_addr;
    logic [1:0]      cur_type;
    logic            cur_we;
    logic [1:0]      cur_off;
    logic [4:0]      shamt;
    logic [BEW-1:0]  size_mask;
    logic [2*BEW-1:0] be_ext;
    logic            cur_mis;
    logic [DW-1:0]   word_addr;
    logic [DW-1:0]   next_word_addr;
    logic [DW-1:0]   wdata_rot;
    logic [2*DW-1:0] rdata_cat;
    logic [DW-1:0]   raw;
    logic [DW-1:0]   load_val;
    logic            resp_err;

    // Attributes come straight from EX while idle, from the latched copy afterwards
    always_comb begin
        if (state_q == IDLE) begin
            cur_addr = adder_result_ex_i;
            cur_type = lsu_type_i;
            cur_we   = lsu_we_i;
        end else begin
            cur_addr = addr_q;
            cur_type = type_q;
            cur_we   = we_q;
        end
    end

    assign cur_off        = cur_addr[1:0];
    assign shamt          = {cur_off, 3'b000};
    assign word_addr      = {cur_addr[DW-1:2], 2'b00};
    assign next_word_addr = word_addr + DW'(4);

    // Byte lanes of the access spread over two words; upper nibble belongs to part 2
    always_comb begin
        size_mask = 4'b1111;
        if (cur_type == TYPE_HALF) begin
            size_mask = 4'b0011;
        end else if (cur_type == TYPE_BYTE) begin
            size_mask = 4'b0001;
        end
    end

    assign be_ext  = {4'b0000, size_mask} << cur_off;
    assign cur_mis = |be_ext[2*BEW-1:BEW];

    // Store data rotated so byte 0 lands on lane off; identical for both parts
    assign wdata_rot = DW'({lsu_wdata_i, lsu_wdata_i} >> (7'd32 - 7'(shamt)));

    // Load assembly: second word supplies the upper bytes of a split access
    always_comb begin
        if (cur_mis) begin
            rdata_cat = {data_rdata_i, rdata_q};
        end else begin
            rdata_cat = {32'h0000_0000, data_rdata_i};
        end
        raw = DW'(rdata_cat >> shamt);
    end

    // Sign or zero extension of sub-word loads
    always_comb begin
        load_val = raw;
        if (type_q == TYPE_HALF) begin
            load_val = sign_q ? {{16{raw[15]}}, raw[15:0]} : {16'h0000, raw[15:0]};
        end else if (type_q == TYPE_BYTE) begin
            load_val = sign_q ? {{24{raw[7]}}, raw[7:0]} : {24'h00_0000, raw[7:0]};
        end
    end

    // State and latched-attribute registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            addr_q  <= '0;
            type_q  <= '0;
            we_q    <= 1'b0;
            sign_q  <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            type_q  <= type_d;
            we_q    <= we_d;
            sign_q  <= sign_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic and per-cycle bus/response controls
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        type_d  = type_q;
        we_d    = we_q;
        sign_d  = sign_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        req_c   = 1'b0;
        part2_c = 1'b0;
        done_c  = 1'b0;
        resp_c  = 1'b0;

        case (state_q)
            IDLE: begin
                if (lsu_req_i) begin
                    req_c  = 1'b1;
                    addr_d = adder_result_ex_i;
                    type_d = lsu_type_i;
                    we_d   = lsu_we_i;
                    sign_d = lsu_sign_ext_i;
                    err_d  = 1'b0;
                    if (data_gnt_i) begin
                        state_d = cur_mis ? WAIT_RVALID_MIS : WAIT_RVALID;
                        done_c  = ~cur_mis;
                    end else begin
                        state_d = cur_mis ? WAIT_GNT_MIS : WAIT_GNT;
                    end
                end
            end

            WAIT_GNT_MIS: begin
                req_c = 1'b1;
                if (data_gnt_i) begin
                    state_d = WAIT_RVALID_MIS;
                end
            end

            WAIT_RVALID_MIS: begin
                if (data_rvalid_i) begin
                    rdata_d = data_rdata_i;
                    err_d   = err_q | data_err_i;
                    req_c   = 1'b1;
                    part2_c = 1'b1;
                    if (data_gnt_i) begin
                        state_d = WAIT_RVALID;
                        done_c  = 1'b1;
                    end else begin
                        state_d = WAIT_GNT;
                    end
                end
            end

            WAIT_GNT: begin
                req_c   = 1'b1;
                part2_c = cur_mis;
                if (data_gnt_i) begin
                    state_d = WAIT_RVALID;
                    done_c  = 1'b1;
                end
            end

            WAIT_RVALID: begin
                if (data_rvalid_i) begin
                    resp_c  = 1'b1;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bus side: qualified by reset so nothing leaks out while rst_ni is low
    always_comb begin
        data_req_o     = req_c & rst_ni;
        lsu_req_done_o = done_c & rst_ni;
        data_addr_o    = '0;
        data_we_o      = 1'b0;
        data_be_o      = '0;
        data_wdata_o   = '0;
        if (data_req_o) begin
            data_addr_o  = part2_c ? next_word_addr : word_addr;
            data_we_o    = cur_we;
            data_be_o    = part2_c ? be_ext[2*BEW-1:BEW] : be_ext[BEW-1:0];
            data_wdata_o = wdata_rot;
        end
    end

    // Writeback side: one response pulse in the final rvalid cycle
    always_comb begin
        resp_err          = resp_c & (err_q | data_err_i);
        lsu_resp_valid_o  = resp_c;
        lsu_resp_err_o    = resp_err;
        lsu_rdata_valid_o = resp_c & ~we_q & ~resp_err;
        load_err_o        = resp_err & ~we_q;
        store_err_o       = resp_err & we_q;
        lsu_rdata_o       = resp_c ? load_val : '0;
    end

    assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_ibex_lsu_lite.sv
// Randomised scoreboard bench for ibex_lsu_lite with a byte-level memory model.
module tb_ibex_lsu_lite;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        lsu_req_i;
    logic        lsu_we_i;
    logic [1:0]  lsu_type_i;
    logic        lsu_sign_ext_i;
    logic [31:0] lsu_wdata_i;
    logic [31:0] adder_result_ex_i;
    logic        lsu_req_done_o;
    logic        data_req_o;
    logic        data_gnt_i;
    logic [31:0] data_addr_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic        data_rvalid_i;
    logic        data_err_i;
    logic [31:0] data_rdata_i;
    logic [31:0] lsu_rdata_o;
    logic        lsu_rdata_valid_o;
    logic        lsu_resp_valid_o;
    logic        lsu_resp_err_o;
    logic        load_err_o;
    logic        store_err_o;
    logic        busy_o;

    ibex_lsu_lite dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .lsu_req_i         (lsu_req_i),
        .lsu_we_i          (lsu_we_i),
        .lsu_type_i        (lsu_type_i),
        .lsu_sign_ext_i    (lsu_sign_ext_i),
        .lsu_wdata_i       (lsu_wdata_i),
        .adder_result_ex_i (adder_result_ex_i),
        .lsu_req_done_o    (lsu_req_done_o),
        .data_req_o        (data_req_o),
        .data_gnt_i        (data_gnt_i),
        .data_addr_o       (data_addr_o),
        .data_we_o         (data_we_o),
        .data_be_o         (data_be_o),
        .data_wdata_o      (data_wdata_o),
        .data_rvalid_i     (data_rvalid_i),
        .data_err_i        (data_err_i),
        .data_rdata_i      (data_rdata_i),
        .lsu_rdata_o       (lsu_rdata_o),
        .lsu_rdata_valid_o (lsu_rdata_valid_o),
        .lsu_resp_valid_o  (lsu_resp_valid_o),
        .lsu_resp_err_o    (lsu_resp_err_o),
        .load_err_o        (load_err_o),
        .store_err_o       (store_err_o),
        .busy_o            (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic        err;
        logic        last;
    } part_t;

    typedef struct {
        logic        we;
        logic        err;
        logic [31:0] rdata;
    } resp_t;

    part_t       part_q[$];
    resp_t       resp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] smem[64];
    logic [7:0]  rmem[256];
    bit          slave_en = 1'b0;
    bit          exp_done = 1'b0;
    bit          aborted  = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Bus slave: random grant latency, random rvalid latency, stray rvalids while nothing is outstanding
    initial begin : slave
        bit          pending;
        int          cnt;
        int          idx;
        part_t       cur;
        logic [31:0] rd;
        pending = 1'b0;
        cnt     = 0;
        forever begin
            @(posedge clk_i);
            if (!slave_en || !rst_ni) begin
                pending  = 1'b0;
                exp_done = 1'b0;
                continue;
            end
            #2;
            data_rvalid_i = 1'b0;
            data_err_i    = 1'b0;
            data_rdata_i  = $urandom;
            if (pending) begin
                if (cnt == 0) begin
                    data_rvalid_i = 1'b1;
                    data_err_i    = cur.err;
                    data_rdata_i  = rd;
                    pending       = 1'b0;
                end else begin
                    cnt--;
                end
            end else if ($urandom_range(9) == 0) begin
                data_rvalid_i = 1'b1;
                data_err_i    = 1'($urandom);
            end
            #1;
            data_gnt_i = 1'b0;
            exp_done   = 1'b0;
            if (data_req_o) begin
                if (part_q.size() == 0) begin
                    check("unexpected_data_req", 32'(data_req_o), 32'd0);
                end else begin
                    check("data_addr", data_addr_o, part_q[0].addr);
                    check("data_be", 32'(data_be_o), 32'(part_q[0].be));
                    check("data_we", 32'(data_we_o), 32'(part_q[0].we));
                    if (part_q[0].we) begin
                        check("data_wdata", data_wdata_o, part_q[0].wdata);
                    end
                    if ($urandom_range(1) == 1) begin
                        data_gnt_i = 1'b1;
                        cur        = part_q.pop_front();
                        exp_done   = cur.last;
                        idx        = int'(data_addr_o[7:2]);
                        rd         = smem[idx];
                        if (data_we_o) begin
                            for (int b = 0; b < 4; b++) begin
                                if (data_be_o[b]) smem[idx][8*b +: 8] = data_wdata_o[8*b +: 8];
                            end
                        end
                        pending = 1'b1;
                        cnt     = $urandom_range(2);
                    end
                end
            end
        end
    end

    // lsu_req_done_o must pulse exactly on the grant of the final part
    always @(negedge clk_i) begin
        if (slave_en && rst_ni) begin
            check("req_done", 32'(lsu_req_done_o), 32'(exp_done));
        end
    end

    // Response monitor: pops the scoreboard whenever a response pulse appears
    always @(negedge clk_i) begin : monitor
        resp_t e;
        if (lsu_resp_valid_o) begin
            if (resp_q.size() == 0) begin
                check("unexpected_resp", 32'(lsu_resp_valid_o), 32'd0);
            end else begin
                e = resp_q.pop_front();
                check("resp_err", 32'(lsu_resp_err_o), 32'(e.err));
                check("rdata_valid", 32'(lsu_rdata_valid_o), 32'(!e.we && !e.err));
                check("load_err", 32'(load_err_o), 32'(!e.we && e.err));
                check("store_err", 32'(store_err_o), 32'(e.we && e.err));
                if (!e.we && !e.err) check("load_data", lsu_rdata_o, e.rdata);
            end
        end else begin
            check("quiet_flags", 32'({lsu_rdata_valid_o, lsu_resp_err_o, load_err_o, store_err_o}), 32'd0);
        end
    end

    // Issue one access: model its bus parts and response, then hold the request until done
    task automatic issue(input logic [1:0] ty, input logic we, input logic sx,
                         input logic [31:0] a, input logic [31:0] wd, input logic e1, input logic e2);
        int          n;
        logic [31:0] b;
        logic [3:0]  be1, be2;
        logic [31:0] wl, v;
        logic [1:0]  ln;
        logic        mis;
        bit          got;
        int          gap;
        part_t       p;
        resp_t       r;
        if (aborted) return;
        n   = (ty == 2'd1) ? 2 : (ty == 2'd2) ? 1 : 4;
        be1 = '0;
        be2 = '0;
        v   = '0;
        wl  = '0;
        for (int i = 0; i < n; i++) begin
            b = a + 32'(i);
            if (b[31:2] == a[31:2]) be1[b[1:0]] = 1'b1;
            else                    be2[b[1:0]] = 1'b1;
            v[8*i +: 8] = rmem[b[7:0]];
        end
        for (int i = 0; i < 4; i++) begin
            ln = a[1:0] + 2'(i);
            wl[8*ln +: 8] = wd[8*i +: 8];
        end
        mis = (be2 != 4'b0000);
        if (sx && n == 2) v = {{16{v[15]}}, v[15:0]};
        if (sx && n == 1) v = {{24{v[7]}}, v[7:0]};
        if (we) begin
            for (int i = 0; i < n; i++) begin
                b = a + 32'(i);
                rmem[b[7:0]] = wd[8*i +: 8];
            end
        end
        p = '{addr: {a[31:2], 2'b00}, be: be1, we: we, wdata: wl, err: e1, last: !mis};
        part_q.push_back(p);
        if (mis) begin
            p = '{addr: {a[31:2], 2'b00} + 32'd4, be: be2, we: we, wdata: wl, err: e2, last: 1'b1};
            part_q.push_back(p);
        end
        r = '{we: we, err: e1 | (mis & e2), rdata: v};
        resp_q.push_back(r);

        lsu_req_i         = 1'b1;
        lsu_we_i          = we;
        lsu_type_i        = ty;
        lsu_sign_ext_i    = sx;
        adder_result_ex_i = a;
        lsu_wdata_i       = wd;
        got = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk_i);
            if (lsu_req_done_o) got = 1'b1;
        end
        if (!got) begin
            check("req_done_timeout", 32'(lsu_req_done_o), 32'd1);
            aborted = 1'b1;
        end
        @(posedge clk_i);
        #1;
        lsu_req_i         = 1'b0;
        lsu_we_i          = 1'($urandom);
        lsu_type_i        = 2'($urandom);
        lsu_sign_ext_i    = 1'($urandom);
        adder_result_ex_i = $urandom;
        lsu_wdata_i       = $urandom;
        gap = $urandom_range(2);
        repeat (gap) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    initial begin
        logic [31:0] ra;
        rst_ni            = 1'b0;
        lsu_req_i         = 1'b1;
        lsu_we_i          = 1'b0;
        lsu_type_i        = 2'd0;
        lsu_sign_ext_i    = 1'b0;
        lsu_wdata_i       = 32'h1234_5678;
        adder_result_ex_i = 32'h0000_0100;
        data_gnt_i        = 1'b1;
        data_rvalid_i     = 1'b1;
        data_err_i        = 1'b0;
        data_rdata_i      = 32'hCAFE_F00D;
        for (int i = 0; i < 64; i++) begin
            smem[i] = (i == 0) ? 32'hDEAD_BEEF : $urandom;
            for (int k = 0; k < 4; k++) rmem[4*i + k] = smem[i][8*k +: 8];
        end

        // Outputs stay quiet in reset even with a request and bus activity present
        #12;
        check("rst_data_req", 32'(data_req_o), 32'd0);
        check("rst_req_done", 32'(lsu_req_done_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_resp_valid", 32'(lsu_resp_valid_o), 32'd0);
        check("rst_rdata", lsu_rdata_o, 32'd0);
        check("rst_addr", data_addr_o, 32'd0);
        check("rst_be", 32'(data_be_o), 32'd0);
        lsu_req_i     = 1'b0;
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Reset while waiting for part 1 rvalid of a misaligned load
        lsu_req_i         = 1'b1;
        lsu_we_i          = 1'b0;
        lsu_type_i        = 2'd0;
        lsu_sign_ext_i    = 1'b0;
        adder_result_ex_i = 32'h0000_0102;
        #1;
        data_gnt_i = 1'b1;
        @(negedge clk_i);
        check("mis_p1_req", 32'(data_req_o), 32'd1);
        check("mis_p1_addr", data_addr_o, 32'h0000_0100);
        check("mis_p1_be", 32'(data_be_o), 32'hC);
        check("mis_p1_done", 32'(lsu_req_done_o), 32'd0);
        @(posedge clk_i);
        #2;
        data_gnt_i = 1'b0;
        check("mis_wait_busy", 32'(busy_o), 32'd1);
        check("mis_wait_req", 32'(data_req_o), 32'd0);
        rst_ni = 1'b0;
        #1;
        check("abort_busy", 32'(busy_o), 32'd0);
        check("abort_req", 32'(data_req_o), 32'd0);
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'h1234_5678;
        #1;
        check("abort_resp", 32'(lsu_resp_valid_o), 32'd0);
        @(posedge clk_i);
        #1;
        rst_ni    = 1'b1;
        lsu_req_i = 1'b0;
        @(negedge clk_i);
        check("post_abort_resp", 32'(lsu_resp_valid_o), 32'd0);
        check("post_abort_busy", 32'(busy_o), 32'd0);
        @(posedge clk_i);
        #1;
        data_rvalid_i = 1'b0;
        slave_en      = 1'b1;

        // Directed corner accesses, then random traffic
        issue(2'd0, 1'b0, 1'b0, 32'h0000_0100, 32'h0, 1'b0, 1'b0);
        issue(2'd2, 1'b0, 1'b1, 32'h0000_0103, 32'h0, 1'b0, 1'b0);
        issue(2'd2, 1'b0, 1'b0, 32'h0000_0103, 32'h0, 1'b0, 1'b0);
        issue(2'd0, 1'b0, 1'b0, 32'h0000_0102, 32'h0, 1'b0, 1'b0);
        issue(2'd1, 1'b1, 1'b0, 32'h0000_0103, 32'h0000_ABCD, 1'b1, 1'b0);
        issue(2'd0, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'hA1B2_C3D4, 1'b0, 1'b0);
        issue(2'd0, 1'b0, 1'b0, 32'hFFFF_FFFD, 32'h0, 1'b0, 1'b0);
        issue(2'd3, 1'b0, 1'b1, 32'h0000_0101, 32'h0, 1'b0, 1'b1);
        for (int t = 0; t < 400; t++) begin
            if ($urandom_range(3) == 0) ra = 32'hFFFF_FFFC + 32'($urandom_range(3));
            else                        ra = $urandom;
            issue(2'($urandom), 1'($urandom), 1'($urandom), ra, $urandom,
                  ($urandom_range(6) == 0), ($urandom_range(6) == 0));
        end

        for (int c = 0; c < 200 && resp_q.size() != 0; c++) @(posedge clk_i);
        if (resp_q.size() != 0) check("resp_drain", 32'(resp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
